// File: rtl/fetch_stage.sv
// Instruction fetch: word requests into a halfword queue, 16/32-bit extract to decode.
// Latency: first instruction 3 cycles after reset release or redirect; 1 instr/cycle steady.
// Backpressure: stall freezes outputs and pops; requests continue until queue+in-flight is full.
//
// Ports:
//   clk, rst_n         clock; rst_n is a synchronous reset asserted HIGH (legacy name)
//   imem_req/addr      word-aligned fetch request; imem_rdata returns one cycle later
//   stall              decode cannot accept this cycle
//   branch_taken/target redirect from execute; wins over stall and drain
//   instruction/pc/compflg/instr_valid  registered instruction presented to decode
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        compflg,
   output logic        instr_valid
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   // The port keeps its historical name but the reset is active-high.
   logic rst;
   assign rst = rst_n;

   logic [15:0]   queue [QDEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          inflight;
   logic [31:0]   fetch_addr;
   logic [31:0]   next_pc;
   logic          skip_low;

   logic [CW:0]   occupancy;
   logic          room_ok;
   logic          push_en;
   logic [CW-1:0] push_cnt;
   logic [CW-1:0] pop_cnt;
   logic [15:0]   hw0;
   logic [15:0]   hw1;
   logic          head_comp;
   logic          drain_ok;
   logic          emit_c;
   logic          emit_w;

   // Occupancy counts an outstanding word as two halfwords so the returning
   // response always has room, even if decode stalls indefinitely.
   always_comb begin
      occupancy = (CW+1)'(count) + (CW+1)'({inflight, 1'b0});
      room_ok   = occupancy <= (CW+1)'(QDEPTH - 2);
      imem_req  = !rst && (branch_taken || room_ok);
      imem_addr = branch_taken ? {branch_target[31:2], 2'b00} : fetch_addr;
   end

   // A redirect in the same cycle discards the response belonging to the old path.
   always_comb begin
      push_en  = inflight && !branch_taken;
      push_cnt = '0;
      if (push_en) begin
         push_cnt = skip_low ? CW'(1) : CW'(2);
      end
   end

   always_comb begin
      hw0       = queue[rd_ptr];
      hw1       = queue[rd_ptr + PW'(1)];
      head_comp = hw0[1:0] != 2'b11;
      drain_ok  = !stall && !branch_taken;
      emit_c    = drain_ok && head_comp && (count != '0);
      emit_w    = drain_ok && !head_comp && (count >= CW'(2));
      pop_cnt   = '0;
      if (emit_c) begin
         pop_cnt = CW'(1);
      end else if (emit_w) begin
         pop_cnt = CW'(2);
      end
   end

   // Halfword storage; validity is tracked only by the pointers and count.
   always_ff @(posedge clk) begin
      if (!rst && push_en) begin
         if (skip_low) begin
            queue[wr_ptr] <= imem_rdata[31:16];
         end else begin
            queue[wr_ptr]           <= imem_rdata[15:0];
            queue[wr_ptr + PW'(1)]  <= imem_rdata[31:16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         inflight    <= 1'b0;
         fetch_addr  <= {RESET_PC[31:2], 2'b00};
         next_pc     <= RESET_PC;
         skip_low    <= RESET_PC[1];
         instruction <= '0;
         pc          <= '0;
         compflg     <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (branch_taken) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_addr  <= {branch_target[31:2], 2'b00} + 32'd4;
            next_pc     <= branch_target & ~32'h1;
            // Target in the upper half of a word: its low halfword is not on the path.
            skip_low    <= branch_target[1];
            instr_valid <= 1'b0;
         end else begin
            if (imem_req) begin
               fetch_addr <= fetch_addr + 32'd4;
            end
            if (push_en) begin
               skip_low <= 1'b0;
            end
            wr_ptr <= wr_ptr + push_cnt[PW-1:0];
            rd_ptr <= rd_ptr + pop_cnt[PW-1:0];
            count  <= count + push_cnt - pop_cnt;
            if (!stall) begin
               if (emit_c) begin
                  instruction <= {16'h0000, hw0};
                  pc          <= next_pc;
                  compflg     <= 1'b1;
                  instr_valid <= 1'b1;
                  next_pc     <= next_pc + 32'd2;
               end else if (emit_w) begin
                  instruction <= {hw1, hw0};
                  pc          <= next_pc;
                  compflg     <= 1'b0;
                  instr_valid <= 1'b1;
                  next_pc     <= next_pc + 32'd4;
               end else begin
                  // Nothing complete to hand over (e.g. second half of a 32-bit
                  // instruction still in flight): keep fields, drop valid.
                  instr_valid <= 1'b0;
               end
            end
         end
      end
   end

endmodule
